stopwatch_display: RTL and testbench

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

---
 rtl/stopwatch_display.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_display.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// Multi-digit BCD stopwatch with up/down counting, lap freeze and a
// time-multiplexed digit scan output (one registered digit per scan slot).
module stopwatch_display #(
  parameter int unsigned     NDIG      = 4,
  parameter int unsigned     TICK_DIV  = 10000000,
  parameter int unsigned     SCAN_DIV  = 2500,
  parameter logic [NDIG-1:0] MOD6_MASK = NDIG'(4'b0100)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       dir,
  input  logic       lap,
  output logic [2:0] hexplay_an,
  output logic [3:0] hexplay_data,
  output logic       running,
  output logic       frozen,
  output logic       wrap,
  output logic       done
);

  localparam int unsigned CW = NDIG * 4;
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);

  logic [CW-1:0] count;
  logic [CW-1:0] snap;
  logic [TW-1:0] div;
  logic [SW-1:0] scan;

  logic [CW-1:0] cnt_up;
  logic [CW-1:0] cnt_dn;
  logic          all_max;
  logic          all_zero;
  logic          tick_c;
  logic [CW-1:0] count_nx;
  logic          run_nx;
  logic          wrap_c;
  logic          done_c;
  logic [CW-1:0] src;
  logic [2:0]    an_nx;
  logic [3:0]    data_nx;

  assign tick_c = running && (div == TW'(TICK_DIV - 1));
  assign src    = frozen ? snap : count;

  // Ripple carry/borrow across the mixed-radix digits
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    logic [3:0] m;
    cnt_up   = count;
    cnt_dn   = count;
    all_max  = 1'b1;
    all_zero = 1'b1;
    carry    = 1'b1;
    borrow   = 1'b1;
    d        = 4'd0;
    m        = 4'd9;
    for (int i = 0; i < int'(NDIG); i++) begin
      d = count[i*4 +: 4];
      m = MOD6_MASK[i] ? 4'd5 : 4'd9;
      if (d != m) all_max = 1'b0;
      if (d != 4'd0) all_zero = 1'b0;
      if (carry) begin
        if (d >= m) begin
          cnt_up[i*4 +: 4] = 4'd0;
        end else begin
          cnt_up[i*4 +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          cnt_dn[i*4 +: 4] = m;
        end else begin
          cnt_dn[i*4 +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Tick effect on count, run state and the wrap/done pulses
  always_comb begin
    count_nx = count;
    run_nx   = running ^ start_stop;
    wrap_c   = 1'b0;
    done_c   = 1'b0;
    if (tick_c) begin
      if (!dir) begin
        count_nx = cnt_up;
        wrap_c   = all_max;
      end else if (all_zero || (cnt_dn == '0)) begin
        count_nx = all_zero ? count : cnt_dn;
        run_nx   = 1'b0;
        done_c   = 1'b1;
      end else begin
        count_nx = cnt_dn;
      end
    end
  end

  // Next scanned digit and its value from the current display source
  always_comb begin
    an_nx   = hexplay_an;
    data_nx = 4'd0;
    if (scan == SW'(SCAN_DIV - 1)) begin
      an_nx = (hexplay_an == 3'(NDIG - 1)) ? 3'd0 : hexplay_an + 3'd1;
    end
    for (int i = 0; i < int'(NDIG); i++) begin
      if (an_nx == 3'(i)) data_nx = src[i*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      snap         <= '0;
      div          <= '0;
      scan         <= '0;
      hexplay_an   <= 3'd0;
      hexplay_data <= 4'd0;
      running      <= 1'b0;
      frozen       <= 1'b0;
      wrap         <= 1'b0;
      done         <= 1'b0;
    end else begin
      scan         <= (scan == SW'(SCAN_DIV - 1)) ? '0 : scan + SW'(1);
      hexplay_an   <= an_nx;
      hexplay_data <= data_nx;
      wrap         <= 1'b0;
      done         <= 1'b0;
      if (clear) begin
        count   <= '0;
        div     <= '0;
        running <= 1'b0;
        frozen  <= 1'b0;
      end else begin
        count   <= count_nx;
        running <= run_nx;
        wrap    <= wrap_c;
        done    <= done_c;
        // The divider holds on the stopping edge so a restart resumes mid-period
        if (tick_c) begin
          div <= '0;
        end else if (running && !start_stop) begin
          div <= div + TW'(1);
        end
        if (lap) begin
          if (frozen) begin
            frozen <= 1'b0;
          end else begin
            frozen <= 1'b1;
            snap   <= count_nx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: stimulus pushes expected display
// contents; a monitor reassembles one full scan and compares.
module tb_stopwatch_display;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       clear;
  logic       dir;
  logic       lap;
  logic [2:0] hexplay_an;
  logic [3:0] hexplay_data;
  logic       running;
  logic       frozen;
  logic       wrap;
  logic       done;

  typedef struct packed {
    logic [15:0] cnt;
    logic        run;
    logic        frz;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   s_cyc = 0;

  stopwatch_display #(
    .NDIG(NDIG), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MOD6_MASK(4'b0100)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .dir(dir),
    .lap(lap), .hexplay_an(hexplay_an), .hexplay_data(hexplay_data),
    .running(running), .frozen(frozen), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: gather every digit slot of one scan, then compare
  initial begin : monitor
    exp_t        e;
    logic [15:0] got;
    logic [3:0]  seen;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e    = sb[0];
        got  = '0;
        seen = '0;
        chk("disp_running", 32'(running), 32'(e.run));
        chk("disp_frozen", 32'(frozen), 32'(e.frz));
        for (int s = 0; s < int'(2 * NDIG * SCAN_DIV) && seen != 4'hF; s++) begin
          if (hexplay_an >= 3'(NDIG)) begin
            chk("an_range", 32'(hexplay_an), 32'(0));
          end else begin
            got[hexplay_an*4 +: 4] = hexplay_data;
            seen[hexplay_an[1:0]]  = 1'b1;
          end
          if (seen != 4'hF) @(negedge clk);
        end
        chk("scan_all_digits", 32'(seen), 32'hF);
        chk("display", 32'(got), 32'(e.cnt));
        void'(sb.pop_front());
      end
    end
  end

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  // Start, then stop on the k-th edge after the start edge
  task automatic run_for(input int k);
    pulse_ss();
    repeat (k - 1) @(negedge clk);
    pulse_ss();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic expect_disp(input logic [15:0] v, input logic r, input logic f);
    exp_t e;
    @(negedge clk);
    e.cnt = v;
    e.run = r;
    e.frz = f;
    sb.push_back(e);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'(0));
  endtask

  initial begin : stim
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; dir = 1'b0; lap = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_running", 32'(running), 32'(0));
    chk("rst_frozen", 32'(frozen), 32'(0));
    chk("rst_wrap", 32'(wrap), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_an", 32'(hexplay_an), 32'(0));
    chk("rst_data", 32'(hexplay_data), 32'(0));
    rst = 1'b0;

    // Idle scan: each digit index held SCAN_DIV cycles
    for (int k = 0; k < 9; k++) begin
      chk("idle_an", 32'(hexplay_an), 32'((k / 2) % 4));
      chk("idle_data", 32'(hexplay_data), 32'(0));
      @(negedge clk);
    end

    run_for(4 * 40);
    expect_disp(16'h0040, 1'b0, 1'b0);
    run_for(4 * 60);
    expect_disp(16'h0100, 1'b0, 1'b0);
    dir = 1'b1;
    run_for(4);
    expect_disp(16'h0099, 1'b0, 1'b0);

    // Reset in the middle of a tick period discards the divider
    dir = 1'b0;
    pulse_ss();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_running", 32'(running), 32'(0));
    expect_disp(16'h0000, 1'b0, 1'b0);
    run_for(3);
    expect_disp(16'h0000, 1'b0, 1'b0);
    do_clear();

    // Full-scale rollover
    run_for(4 * 5999);
    expect_disp(16'h9599, 1'b0, 1'b0);
    pulse_ss();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("wrap_pulse", 32'(wrap), 32'(k == 4));
      chk("wrap_running", 32'(running), 32'(1));
    end
    do_clear();
    chk("clear_running", 32'(running), 32'(0));
    expect_disp(16'h0000, 1'b0, 1'b0);

    // Count down to zero, then attempt a down tick from zero
    run_for(8);
    expect_disp(16'h0002, 1'b0, 1'b0);
    dir = 1'b1;
    pulse_ss();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'(k == 8));
      chk("done_running", 32'(running), 32'(k < 8));
    end
    repeat (10) @(negedge clk);
    expect_disp(16'h0000, 1'b0, 1'b0);
    pulse_ss();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("zero_done_pulse", 32'(done), 32'(k == 4));
      chk("zero_running", 32'(running), 32'(k < 4));
    end
    expect_disp(16'h0000, 1'b0, 1'b0);

    // Stop mid-period keeps divider phase; clear beats start_stop
    dir = 1'b0;
    do_clear();
    run_for(3);
    expect_disp(16'h0000, 1'b0, 1'b0);
    run_for(1);
    expect_disp(16'h0000, 1'b0, 1'b0);
    run_for(2);
    expect_disp(16'h0001, 1'b0, 1'b0);
    pulse_ss();
    chk("restart_running", 32'(running), 32'(1));
    clear = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start_stop = 1'b0;
    chk("clear_ss_running", 32'(running), 32'(0));
    expect_disp(16'h0000, 1'b0, 1'b0);

    // Lap freeze while the live count keeps going
    do_clear();
    run_for(4 * 12);
    expect_disp(16'h0012, 1'b0, 1'b0);
    pulse_ss();
    s_cyc = cyc;
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    chk("lap_frozen", 32'(frozen), 32'(1));
    expect_disp(16'h0012, 1'b1, 1'b1);
    while (cyc < s_cyc + 31) @(negedge clk);
    pulse_ss();
    expect_disp(16'h0012, 1'b0, 1'b1);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    chk("unlap_frozen", 32'(frozen), 32'(0));
    expect_disp(16'h0020, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
